pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It sits beside the decode stage, taking decode's register fields and control signals. It mirrors the X/M/W occupancy in a small shadow scoreboard and produces stall, bubble, flush and operand-forwarding selects. It also holds the pipeline for the multi-cycle multiplier.

## Interface
- MUL_CYCLES, 3: execute-stage occupancy of a MUL, in cycles (≥1).
- clk_in  in  1  CPU clock; all state updates on posedge.
- rst_in  in  1  asynchronous, active-high reset.
- d_valid  in  1  decode holds a real instruction (0 = NOP/bubble).
- d_rs, d_rt  in  5 each  source register addresses of the decode instruction.
- d_uses_rs, d_uses_rt  in  1 each  instruction actually reads that source.
- d_wb_we  in  1  decode instruction writes the register file.
- d_wb_reg_addr  in  5  destination register.
- d_is_load  in  1  LW/LB/LBU: mem_out_sel=0 with wb_we=1.
- d_is_mul  in  1  MUL (SPECIAL2).
- x_redirect  in  1  taken branch or jump resolved in execute this cycle.
- stall  out  1  hold the PC and F/D registers.
- bubble  out  1  load NOP into D/X instead of the decode instruction.
- flush  out  1  replace the instruction entering F/D with NOP.
- fwd_a_sel, fwd_b_sel  out  2 each  execute operand source: 00 = regfile, 01 = X/M result, 10 = M/W result.
- mul_busy  out  1  a MUL is occupying execute.

## Operation
- Scoreboard: three slots X, M, W. Each slot holds {valid, we, dest, is_load, rs, rt}.
- The scoreboard advances every cycle: W←M, M←X, X←decode entry.
- The X entry is a bubble (valid=0) when bubble=1, when d_valid=0, or when flush was asserted last cycle.
- A slot matches source r when valid & we & dest==r & dest!=0 & the source is used. Register 0 never causes a hazard.
- With FORWARD_EN, hazard = X slot is_load and matches d_rs or d_rt (load-use).
- Without FORWARD_EN, hazard = X, M or W slot matches. The register file is not write-through.
- stall = bubble = d_valid & hazard, or state MUL_WAIT.
- FSM states: RUN and MUL_WAIT.
  - RUN → MUL_WAIT when a valid MUL enters X and MUL_CYCLES>1. The counter loads MUL_CYCLES-1.
  - In MUL_WAIT, the X slot is frozen. M receives bubbles. The counter decrements each cycle.
  - MUL_WAIT → RUN when the counter reaches 1. The MUL advances to M on that edge.
- mul_busy = (state==MUL_WAIT).
- Redirect: flush = x_redirect. The branch delay slot (the instruction currently in decode) is never flushed.
- Redirect during a stall: flush still kills the fetched instruction, and the delay slot remains held.
- Forwarding (FORWARD_EN only): for the X-slot rs, the sel is 01 if the M slot matches and is not a load; otherwise 10 if the W slot matches; otherwise 00. M has priority over W. The same rule applies to rt.

## Timing
- stall, bubble, flush and fwd_* are combinational from inputs and registered state, valid in the same cycle.
- Scoreboard, FSM and counter are registered.
- Reset (async, immediate): all slots invalid, state RUN, counter 0. All outputs 0.
- Reset mid-MUL drops to RUN with no stall on the cycle after deassertion.
- Load-use with forwarding costs exactly 1 bubble. Without forwarding, a dependent instruction immediately behind its producer costs 3 bubbles.
- A MUL costs MUL_CYCLES-1 stall cycles. With MUL_CYCLES=1, MUL_WAIT is never entered.
- When a hazard and MUL_WAIT coincide, stall is asserted and the hazard is re-evaluated after the wait.

## Configuration
- FORWARD_EN defined:
  - Forwarding paths are active.
  - Only load-use hazards stall.
- FORWARD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - Every RAW hazard against X, M or W stalls.
- MUL sequencing and redirect behave identically in both builds.

## Structure
- Constants go in const.v: FWD_REG=2'b00, FWD_XM=2'b01, FWD_MW=2'b10, and the state encodings ST_RUN and ST_MUL_WAIT.
- Sub-module hazard_scoreboard: the three shadow slots plus the match logic, instanced once.
- The top level holds the FSM, the counter and the output muxing.

## Test plan
- Load-use: LW r8,0(r9) then ADD r10,r8,r11 → one cycle of stall=bubble=1; then fwd_a_sel=10 with ADD in X. Without FORWARD_EN: three stall cycles, then fwd_a_sel=00.
- Back-to-back ALU: ADDI r2,r0,5 then ADD r3,r2,r2 → no stall; fwd_a_sel=fwd_b_sel=01.
- Zero register: LW r0,4(r1) then ADD r4,r0,r0 → no stall, fwd sels 00.
- MUL with MUL_CYCLES=3: MUL r5,r6,r7 followed by an independent ADD → mul_busy=1 and stall=1 for 2 cycles, then the MUL reaches M and the ADD enters X.
- Redirect: BEQ taken with x_redirect=1 while its delay slot is stalled on a load → flush=1 for 1 cycle, delay slot still issues, fetched instruction becomes NOP.
- Async reset asserted in MUL_WAIT mid-count → stall, bubble, flush, mul_busy and fwd_* drop to 0 immediately; after release, the first instruction issues without stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared constants, FSM states and scoreboard slot type for pipeline_ctrl
package pipeline_ctrl_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_XM  = 2'b01;
  localparam logic [1:0] FWD_MW  = 2'b10;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] dest;
    logic       is_load;
    logic [4:0] rs;
    logic [4:0] rt;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // Unused sources are carried as r0, so a dest of r0 never produces a hit.
  function automatic logic slot_match(input logic       valid,
                                      input logic       we,
                                      input logic [4:0] dest,
                                      input logic [4:0] src);
    return valid & we & (dest == src) & (dest != 5'd0);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - decode-side request and hazard-control response bundle
interface pipeline_ctrl_if;

  logic       d_valid;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic       d_uses_rs;
  logic       d_uses_rt;
  logic       d_wb_we;
  logic [4:0] d_wb_reg_addr;
  logic       d_is_load;
  logic       d_is_mul;
  logic       x_redirect;

  logic       stall;
  logic       bubble;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       mul_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_uses_rs, d_uses_rt, d_wb_we, d_wb_reg_addr,
           d_is_load, d_is_mul, x_redirect,
    input  stall, bubble, flush, fwd_a_sel, fwd_b_sel, mul_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_uses_rs, d_uses_rt, d_wb_we, d_wb_reg_addr,
           d_is_load, d_is_mul, x_redirect,
    output stall, bubble, flush, fwd_a_sel, fwd_b_sel, mul_busy
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// rtl/pipeline_ctrl_hazard_scoreboard.sv - X/M/W shadow slots and RAW match logic; FORWARD_EN selects load-use-only stalls plus forwarding
module pipeline_ctrl_hazard_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       freeze_x,
  input  slot_t      x_entry,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  output logic       hazard,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  slot_t x_q;
  slot_t m_q;
  slot_t w_q;
  logic  x_hit;
  logic  unused_fields;

  // While a MUL holds execute, X keeps its contents and M is fed bubbles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      x_q <= SLOT_EMPTY;
      m_q <= SLOT_EMPTY;
      w_q <= SLOT_EMPTY;
    end else begin
      w_q <= m_q;
      if (freeze_x) begin
        m_q <= SLOT_EMPTY;
      end else begin
        m_q <= x_q;
        x_q <= x_entry;
      end
    end
  end

  assign x_hit = slot_match(x_q.valid, x_q.we, x_q.dest, d_rs) |
                 slot_match(x_q.valid, x_q.we, x_q.dest, d_rt);

`ifdef FORWARD_EN
  logic m_hit_a;
  logic m_hit_b;
  logic w_hit_a;
  logic w_hit_b;

  // A load in M has no result on the X/M bus yet, so it may only forward from W.
  assign m_hit_a = slot_match(m_q.valid, m_q.we, m_q.dest, x_q.rs) & ~m_q.is_load;
  assign m_hit_b = slot_match(m_q.valid, m_q.we, m_q.dest, x_q.rt) & ~m_q.is_load;
  assign w_hit_a = slot_match(w_q.valid, w_q.we, w_q.dest, x_q.rs);
  assign w_hit_b = slot_match(w_q.valid, w_q.we, w_q.dest, x_q.rt);

  assign fwd_a_sel = m_hit_a ? FWD_XM : (w_hit_a ? FWD_MW : FWD_REG);
  assign fwd_b_sel = m_hit_b ? FWD_XM : (w_hit_b ? FWD_MW : FWD_REG);
  assign hazard    = x_q.is_load & x_hit;

  assign unused_fields = ^{m_q.rs, m_q.rt, w_q.is_load, w_q.rs, w_q.rt};
`else
  logic m_hit;
  logic w_hit;

  // No write-through register file: a producer still in W blocks its consumer too.
  assign m_hit = slot_match(m_q.valid, m_q.we, m_q.dest, d_rs) |
                 slot_match(m_q.valid, m_q.we, m_q.dest, d_rt);
  assign w_hit = slot_match(w_q.valid, w_q.we, w_q.dest, d_rs) |
                 slot_match(w_q.valid, w_q.we, w_q.dest, d_rt);

  assign hazard    = x_hit | m_hit | w_hit;
  assign fwd_a_sel = FWD_REG;
  assign fwd_b_sel = FWD_REG;

  assign unused_fields = ^{x_q.is_load, x_q.rs, x_q.rt,
                           m_q.is_load, m_q.rs, m_q.rt,
                           w_q.is_load, w_q.rs, w_q.rt};
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - MIPS 5-stage hazard, redirect and MUL sequencing controller; FORWARD_EN enables forwarding
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 3
) (
  input logic            clk_in,
  input logic            rst_in,
  pipeline_ctrl_if.slave ctrl
);

  localparam int               CNT_W     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam bit               MUL_MULTI = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             flush_q;

  logic       mul_wait;
  logic       hazard;
  logic       stall_c;
  logic       entry_valid;
  logic       freeze_x;
  logic [4:0] rs_src;
  logic [4:0] rt_src;
  slot_t      x_entry;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign mul_wait = (state_q == ST_MUL_WAIT);
  assign rs_src   = ctrl.d_uses_rs ? ctrl.d_rs : 5'd0;
  assign rt_src   = ctrl.d_uses_rt ? ctrl.d_rt : 5'd0;
  assign stall_c  = (ctrl.d_valid & hazard) | mul_wait;

  // After an unstalled redirect, decode holds the killed fetch; keep it out of X.
  assign entry_valid = ctrl.d_valid & ~stall_c & ~flush_q;
  assign freeze_x    = mul_wait & (cnt_q != CNT_ONE);

  always_comb begin
    x_entry = SLOT_EMPTY;
    if (entry_valid) begin
      x_entry.valid   = 1'b1;
      x_entry.we      = ctrl.d_wb_we;
      x_entry.dest    = ctrl.d_wb_reg_addr;
      x_entry.is_load = ctrl.d_is_load;
      x_entry.rs      = rs_src;
      x_entry.rt      = rt_src;
    end
  end

  pipeline_ctrl_hazard_scoreboard u_hazard_scoreboard (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .freeze_x  (freeze_x),
    .x_entry   (x_entry),
    .d_rs      (rs_src),
    .d_rt      (rt_src),
    .hazard    (hazard),
    .fwd_a_sel (fwd_a),
    .fwd_b_sel (fwd_b)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (MUL_MULTI && entry_valid && ctrl.d_is_mul) begin
          state_d = ST_MUL_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // A redirect raised while stalled leaves the delay slot in decode, so it must not arm the kill.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= ctrl.x_redirect & ~stall_c;
    end
  end

  assign ctrl.stall     = stall_c;
  assign ctrl.bubble    = stall_c;
  assign ctrl.flush     = ctrl.x_redirect & ~rst_in;
  assign ctrl.mul_busy  = mul_wait;
  assign ctrl.fwd_a_sel = fwd_a;
  assign ctrl.fwd_b_sel = fwd_b;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed-vector bench for pipeline_ctrl (MUL_CYCLES=3), FORWARD_EN-aware
module tb_pipeline_ctrl;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_checks = 0;
  int   n_pass   = 0;

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.MUL_CYCLES(3)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .ctrl   (pif)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       we;
    logic [4:0] wd;
    logic       ld;
    logic       mul;
  } ins_t;

  function automatic ins_t nop();
    ins_t i = '0;
    return i;
  endfunction

  function automatic ins_t alu(input logic [4:0] wd, input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = '0;
    i.v = 1'b1; i.rs = rs; i.rt = rt; i.urs = 1'b1; i.urt = 1'b1; i.we = 1'b1; i.wd = wd;
    return i;
  endfunction

  // I-type: rt field carries the destination and is not read.
  function automatic ins_t alui(input logic [4:0] wd, input logic [4:0] rs);
    ins_t i = '0;
    i.v = 1'b1; i.rs = rs; i.rt = wd; i.urs = 1'b1; i.urt = 1'b0; i.we = 1'b1; i.wd = wd;
    return i;
  endfunction

  function automatic ins_t lw(input logic [4:0] wd, input logic [4:0] base);
    ins_t i = alui(wd, base);
    i.ld = 1'b1;
    return i;
  endfunction

  function automatic ins_t mulop(input logic [4:0] wd, input logic [4:0] rs, input logic [4:0] rt);
    ins_t i = alu(wd, rs, rt);
    i.mul = 1'b1;
    return i;
  endfunction

  // Packed as {stall, bubble, flush, mul_busy, fwd_a_sel, fwd_b_sel}.
  function automatic logic [7:0] ex(input bit st, input bit fl, input bit mb,
                                    input logic [1:0] fa, input logic [1:0] fb);
    return {st, st, fl, mb, fa, fb};
  endfunction

  logic [7:0] obs;
  assign obs = {pif.stall, pif.bubble, pif.flush, pif.mul_busy, pif.fwd_a_sel, pif.fwd_b_sel};

  localparam logic [7:0] IDLE = 8'h00;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b want %b {stall,bubble,flush,mul_busy,fwd_a,fwd_b}", tag, got, exp);
  endtask

  task automatic drive(input ins_t i, input logic redir);
    pif.d_valid       = i.v;
    pif.d_rs          = i.rs;
    pif.d_rt          = i.rt;
    pif.d_uses_rs     = i.urs;
    pif.d_uses_rt     = i.urt;
    pif.d_wb_we       = i.we;
    pif.d_wb_reg_addr = i.wd;
    pif.d_is_load     = i.ld;
    pif.d_is_mul      = i.mul;
    pif.x_redirect    = redir;
  endtask

  task automatic step(input string tag, input ins_t i, input logic redir, input logic [7:0] exp);
    @(negedge clk_in);
    drive(i, redir);
    #1;
    check(tag, obs, exp);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 3; k++) step(tag, nop(), 1'b0, IDLE);
  endtask

  initial begin
    rst_in = 1'b1;
    drive(alu(10, 8, 11), 1'b0);
    #7;
    check("reset", obs, IDLE);
    @(negedge clk_in);
    drive(nop(), 1'b0);
    rst_in = 1'b0;

    // LW r8,0(r9) ; ADD r10,r8,r11
    step("lu_ld", lw(8, 9), 1'b0, IDLE);
`ifdef FORWARD_EN
    step("lu_stall", alu(10, 8, 11), 1'b0, ex(1, 0, 0, 2'b00, 2'b00));
    step("lu_issue", alu(10, 8, 11), 1'b0, IDLE);
    step("lu_fwd", nop(), 1'b0, ex(0, 0, 0, 2'b10, 2'b00));
`else
    for (int k = 0; k < 3; k++) step("lu_stall", alu(10, 8, 11), 1'b0, ex(1, 0, 0, 2'b00, 2'b00));
    step("lu_issue", alu(10, 8, 11), 1'b0, IDLE);
    step("lu_fwd", nop(), 1'b0, IDLE);
`endif
    drain("lu_drain");

    // ADDI r2,r0,5 ; ADD r3,r2,r2
    step("b2b_addi", alui(2, 0), 1'b0, IDLE);
`ifdef FORWARD_EN
    step("b2b_add", alu(3, 2, 2), 1'b0, IDLE);
    step("b2b_fwd", nop(), 1'b0, ex(0, 0, 0, 2'b01, 2'b01));
`else
    for (int k = 0; k < 3; k++) step("b2b_stall", alu(3, 2, 2), 1'b0, ex(1, 0, 0, 2'b00, 2'b00));
    step("b2b_add", alu(3, 2, 2), 1'b0, IDLE);
    step("b2b_fwd", nop(), 1'b0, IDLE);
`endif
    drain("b2b_drain");

    // LW r0,4(r1) ; ADD r4,r0,r0
    step("z_ld", lw(0, 1), 1'b0, IDLE);
    step("z_add", alu(4, 0, 0), 1'b0, IDLE);
    step("z_fwd", nop(), 1'b0, IDLE);
    drain("z_drain");

    // MUL r5,r6,r7 ; ADD r8,r1,r2
    step("mul_issue", mulop(5, 6, 7), 1'b0, IDLE);
    step("mul_wait1", alu(8, 1, 2), 1'b0, ex(1, 0, 1, 2'b00, 2'b00));
    step("mul_wait2", alu(8, 1, 2), 1'b0, ex(1, 0, 1, 2'b00, 2'b00));
    step("mul_add", alu(8, 1, 2), 1'b0, IDLE);
    step("mul_after", nop(), 1'b0, IDLE);
    drain("mul_drain");

    // Redirect while the delay slot is stalled on a load
    step("rd_ld", lw(8, 9), 1'b0, IDLE);
    step("rd_flush", alu(10, 8, 11), 1'b1, ex(1, 1, 0, 2'b00, 2'b00));
`ifdef FORWARD_EN
    step("rd_ds_issue", alu(10, 8, 11), 1'b0, IDLE);
    step("rd_ds_in_x", nop(), 1'b0, ex(0, 0, 0, 2'b10, 2'b00));
`else
    for (int k = 0; k < 2; k++) step("rd_stall", alu(10, 8, 11), 1'b0, ex(1, 0, 0, 2'b00, 2'b00));
    step("rd_ds_issue", alu(10, 8, 11), 1'b0, IDLE);
    step("rd_ds_in_x", alu(12, 10, 0), 1'b0, ex(1, 0, 0, 2'b00, 2'b00));
`endif
    drain("rd_drain");

    // Unstalled redirect: the instruction decoded next cycle must not reach X
    step("fl_ds", alu(13, 0, 0), 1'b1, ex(0, 1, 0, 2'b00, 2'b00));
    step("fl_kill", alu(14, 0, 0), 1'b0, IDLE);
    step("fl_dep", alu(15, 14, 14), 1'b0, IDLE);
    step("fl_chk", nop(), 1'b0, IDLE);
    drain("fl_drain");

    // Async reset in the middle of a MUL wait
    step("rm_mul", mulop(5, 6, 7), 1'b0, IDLE);
    step("rm_wait", alu(8, 1, 2), 1'b0, ex(1, 0, 1, 2'b00, 2'b00));
    #1;
    rst_in = 1'b1;
    #1;
    check("rm_async", obs, IDLE);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rm_release", obs, IDLE);
    step("rm_next", nop(), 1'b0, IDLE);
    step("rm_idle", nop(), 1'b0, IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
